// File: rtl/decoder_bj_pipe.sv
// decoder_bj_pipe: registered multi-lane branch/jump decoder with a 2-entry skid buffer.
// Defining DECODER_BJ_STATS_EN adds the stat_bj_cnt / stat_stall_cnt counters.
`ifndef INVALID_OP_4B
`define INVALID_OP_4B 4'hF
`define BJ_B          4'h1
`define BJ_BL         4'h2
`define BJ_BEQ        4'h3
`define BJ_BNE        4'h4
`define BJ_BLT        4'h5
`define BJ_BGE        4'h6
`define BJ_BLTU       4'h7
`define BJ_BGEU       4'h8
`define BJ_JIRL       4'h9
`endif

module decoder_bj_pipe #(
  parameter int LANES = 2,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES*PC_W-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_is_bj,
  output logic [LANES*4-1:0]    out_bj_op,
  output logic [LANES*PC_W-1:0] out_tgt,
  output logic [LANES-1:0]      out_tgt_vld,
  output logic [LANES-1:0]      out_first_bj
`ifdef DECODER_BJ_STATS_EN
  ,
  output logic [31:0]           stat_bj_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  typedef enum logic [1:0] {st_empty, st_one, st_two} state_t;

  function automatic logic [3:0] bj_decode(input logic vld, input logic [31:0] ins);
    logic [3:0] op;
    op = `INVALID_OP_4B;
    if (vld && ins[31:30] == 2'b01) begin
      case (ins[29:26])
        4'b0011: op = `BJ_JIRL;
        4'b0100: op = `BJ_B;
        4'b0101: op = `BJ_BL;
        4'b0110: op = `BJ_BEQ;
        4'b0111: op = `BJ_BNE;
        4'b1000: op = `BJ_BLT;
        4'b1001: op = `BJ_BGE;
        4'b1010: op = `BJ_BLTU;
        4'b1011: op = `BJ_BGEU;
        default: op = `INVALID_OP_4B;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_long_jump(input logic [3:0] op);
    return (op == `BJ_B) || (op == `BJ_BL);
  endfunction

  function automatic logic has_target(input logic [3:0] op);
    return (op != `INVALID_OP_4B) && (op != `BJ_JIRL);
  endfunction

  // JIRL and non-BJ lanes report a zero target since their base is not the PC.
  function automatic logic [PC_W-1:0] bj_target(input logic [3:0] op, input logic [31:0] ins,
                                                input logic [PC_W-1:0] pc);
    logic signed [PC_W-1:0] offs;
    if (is_long_jump(op))
      offs = $signed({{(PC_W-26){ins[9]}}, ins[9:0], ins[25:10]}) <<< 2;
    else
      offs = $signed({{(PC_W-16){ins[25]}}, ins[25:10]}) <<< 2;
    return has_target(op) ? pc + $unsigned(offs) : '0;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // ---- stage p0: combinational decode of the incoming bundle
  logic [LANES-1:0]      dec_is_bj_p0;
  logic [LANES*4-1:0]    dec_op_p0;
  logic [LANES*PC_W-1:0] dec_tgt_p0;
  logic [LANES-1:0]      dec_tgt_vld_p0;

  always_comb begin
    dec_is_bj_p0   = '0;
    dec_op_p0      = '0;
    dec_tgt_p0     = '0;
    dec_tgt_vld_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      dec_op_p0[4*i +: 4]        = bj_decode(in_lane_vld[i], in_instr[32*i +: 32]);
      dec_is_bj_p0[i]            = (dec_op_p0[4*i +: 4] != `INVALID_OP_4B);
      dec_tgt_vld_p0[i]          = has_target(dec_op_p0[4*i +: 4]);
      dec_tgt_p0[PC_W*i +: PC_W] = bj_target(dec_op_p0[4*i +: 4], in_instr[32*i +: 32],
                                             in_pc[PC_W*i +: PC_W]);
    end
  end

  // ---- control: O/S occupancy state machine
  state_t state, state_n;
  logic   in_ready_q;
  logic   accept, drain;
  logic   load_o_in, load_o_s, load_s;

  assign accept    = in_valid && in_ready_q;
  assign drain     = (state != st_empty) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != st_empty);

  always_comb begin
    state_n   = state;
    load_o_in = 1'b0;
    load_o_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_n = st_empty;
    end else begin
      case (state)
        st_empty: if (accept) begin
          state_n   = st_one;
          load_o_in = 1'b1;
        end
        st_one: begin
          if (accept && drain) begin
            load_o_in = 1'b1;
          end else if (accept) begin
            state_n = st_two;
            load_s  = 1'b1;
          end else if (drain) begin
            state_n = st_empty;
          end
        end
        st_two: if (drain) begin
          state_n  = st_one;
          load_o_s = 1'b1;
        end
        default: state_n = st_empty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= st_empty;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != st_two);
    end
  end

  // ---- stage p1: output register O and skid register S
  logic [LANES-1:0]      o_is_bj_p1, s_is_bj_p1;
  logic [LANES*4-1:0]    o_op_p1, s_op_p1;
  logic [LANES*PC_W-1:0] o_tgt_p1, s_tgt_p1;
  logic [LANES-1:0]      o_tgt_vld_p1, s_tgt_vld_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_is_bj_p1   <= '0;
      o_op_p1      <= {LANES{`INVALID_OP_4B}};
      o_tgt_p1     <= '0;
      o_tgt_vld_p1 <= '0;
    end else if (load_o_in) begin
      o_is_bj_p1   <= dec_is_bj_p0;
      o_op_p1      <= dec_op_p0;
      o_tgt_p1     <= dec_tgt_p0;
      o_tgt_vld_p1 <= dec_tgt_vld_p0;
    end else if (load_o_s) begin
      o_is_bj_p1   <= s_is_bj_p1;
      o_op_p1      <= s_op_p1;
      o_tgt_p1     <= s_tgt_p1;
      o_tgt_vld_p1 <= s_tgt_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_s) begin
      s_is_bj_p1   <= dec_is_bj_p0;
      s_op_p1      <= dec_op_p0;
      s_tgt_p1     <= dec_tgt_p0;
      s_tgt_vld_p1 <= dec_tgt_vld_p0;
    end
  end

  assign out_is_bj    = o_is_bj_p1;
  assign out_bj_op    = o_op_p1;
  assign out_tgt      = o_tgt_p1;
  assign out_tgt_vld  = o_tgt_vld_p1;
  // Isolate the lowest set bit: x & (~x + 1).
  assign out_first_bj = o_is_bj_p1 & (~o_is_bj_p1 + LANES'(1));

`ifdef DECODER_BJ_STATS_EN
  logic [31:0] stat_bj_cnt_q, stat_stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bj_cnt_q    <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      if (drain)
        stat_bj_cnt_q <= sat_add32(stat_bj_cnt_q, 32'($countones(o_is_bj_p1)));
      if (out_valid && !out_ready)
        stat_stall_cnt_q <= sat_add32(stat_stall_cnt_q, 32'd1);
    end
  end

  assign stat_bj_cnt    = stat_bj_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule
